// File: rtl/regbank_arb_pkg.sv
// Shared definitions for the register-bank operation arbiter: FunSel opcodes
// understood by the bank and the service FSM state encoding.
package regbank_arb_pkg;

  localparam logic [2:0] FS_DEC    = 3'b000;
  localparam logic [2:0] FS_INC    = 3'b001;
  localparam logic [2:0] FS_LOAD   = 3'b010;
  localparam logic [2:0] FS_CLR    = 3'b011;
  localparam logic [2:0] FS_CLR_WL = 3'b100;
  localparam logic [2:0] FS_WL     = 3'b101;
  localparam logic [2:0] FS_WH     = 3'b110;
  localparam logic [2:0] FS_SEXT   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational requester picker. Round-robin from i_ptr by default;
// with ARB_FIXED_PRIORITY_EN defined the lowest index always wins and i_ptr is ignored.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDX_W-1:0]   o_idx
);

  logic w_found;

`ifdef ARB_FIXED_PRIORITY_EN
  // Lowest-index requester wins.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_found && i_req[i]) begin
        w_found    = 1'b1;
        o_grant[i] = 1'b1;
        o_idx      = IDX_W'(i);
      end else begin
        w_found = w_found;
      end
    end
  end
`else
  int w_k;

  // Rotating search starting at the pointer; first asserted request wins.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_k     = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_k = (int'(i_ptr) + i) % NUM_REQ;
      if (!w_found && i_req[w_k]) begin
        w_found      = 1'b1;
        o_grant[w_k] = 1'b1;
        o_idx        = IDX_W'(w_k);
      end else begin
        w_found = w_found;
      end
    end
  end
`endif

endmodule

// File: rtl/regbank_op_arbiter.sv
// Serialises register-bank operations from NUM_REQ requesters, one op per 3 cycles.
// Build option: ARB_FIXED_PRIORITY_EN selects fixed priority instead of round-robin.
module regbank_op_arbiter
  import regbank_arb_pkg::*;
#(
  parameter int NUM_REQ  = 2,
  parameter int NUM_REGS = 4,
  parameter int SEL_W    = 2
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [NUM_REQ-1:0]        i_req_valid,
  input  logic [3*NUM_REQ-1:0]      i_req_fun_sel,
  input  logic [SEL_W*NUM_REQ-1:0]  i_req_sel,
  input  logic [16*NUM_REQ-1:0]     i_req_data,
  output logic [NUM_REQ-1:0]        o_ack,
  output logic [15:0]               o_rdata,
  output logic [NUM_REGS-1:0]       o_reg_e,
  output logic [2:0]                o_reg_fun_sel,
  output logic [15:0]               o_reg_i,
  input  logic [16*NUM_REGS-1:0]    i_reg_q,
  output logic                      o_busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_e               r_state;
  logic [NUM_REQ-1:0]   r_grant;
  logic [SEL_W-1:0]     r_sel;
  logic [2:0]           r_fun_sel;
  logic [15:0]          r_data;
  logic [NUM_REGS-1:0]  r_reg_e;
  logic [NUM_REQ-1:0]   r_ack;

  logic [IDX_W-1:0]     w_ptr;
  logic [NUM_REQ-1:0]   w_grant;
  logic [IDX_W-1:0]     w_idx;
  logic [2:0]           w_win_fs;
  logic [SEL_W-1:0]     w_win_sel;
  logic [15:0]          w_win_data;
  logic [NUM_REGS-1:0]  w_sel_dec;
  logic [15:0]          w_rdata;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_arb (
    .i_req   (i_req_valid),
    .i_ptr   (w_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx)
  );

`ifdef ARB_FIXED_PRIORITY_EN
  assign w_ptr = '0;
`else
  logic [IDX_W-1:0] r_ptr;

  // Round-robin pointer advances past the winner on every grant.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr <= '0;
    end else if (r_state == ST_IDLE && |i_req_valid) begin
      r_ptr <= (w_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_idx + IDX_W'(1);
    end else begin
      r_ptr <= r_ptr;
    end
  end

  assign w_ptr = r_ptr;
`endif

  // Winner's operation fields, taken straight from the request buses.
  always_comb begin
    w_win_fs   = i_req_fun_sel[w_idx*3 +: 3];
    w_win_sel  = i_req_sel[w_idx*SEL_W +: SEL_W];
    w_win_data = i_req_data[w_idx*16 +: 16];
  end

  // One-hot register enable; an out-of-range select decodes to all zero.
  always_comb begin
    w_sel_dec = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (w_win_sel == SEL_W'(k)) begin
        w_sel_dec[k] = 1'b1;
      end else begin
        w_sel_dec[k] = 1'b0;
      end
    end
  end

  // Post-update readback, only meaningful in DONE; zero for an out-of-range select.
  always_comb begin
    w_rdata = 16'h0000;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (r_state == ST_DONE && r_sel == SEL_W'(k)) begin
        w_rdata = i_reg_q[16*k +: 16];
      end else begin
        w_rdata = w_rdata;
      end
    end
  end

  // Service FSM: latch the winner in IDLE, enable the bank in ISSUE, acknowledge in DONE.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_grant   <= '0;
      r_sel     <= '0;
      r_fun_sel <= 3'b000;
      r_data    <= 16'h0000;
      r_reg_e   <= '0;
      r_ack     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_ack <= '0;
          if (|i_req_valid) begin
            r_state   <= ST_ISSUE;
            r_grant   <= w_grant;
            r_sel     <= w_win_sel;
            r_fun_sel <= w_win_fs;
            r_data    <= w_win_data;
            r_reg_e   <= w_sel_dec;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          r_reg_e <= '0;
          r_ack   <= r_grant;
          r_state <= ST_DONE;
        end
        ST_DONE: begin
          r_ack   <= '0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_reg_e <= '0;
          r_ack   <= '0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_ack         = r_ack;
  assign o_rdata       = w_rdata;
  assign o_reg_e       = r_reg_e;
  assign o_reg_fun_sel = r_fun_sel;
  assign o_reg_i       = r_data;
  assign o_busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_regbank_op_arbiter.sv
// Directed bench for regbank_op_arbiter: a behavioural register bank closes the loop,
// a vector table covers the opcodes, hand sequences cover reset, contention and bad select.
module tb_regbank_op_arbiter;
  import regbank_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        bank_rst_n = 1'b0;

  logic [1:0]  req_valid, req_valid3;
  logic [5:0]  req_fs, req_fs3;
  logic [3:0]  req_sel, req_sel3;
  logic [31:0] req_data, req_data3;
  logic [1:0]  ack, ack3;
  logic [15:0] rdata, rdata3, reg_i, reg_i3;
  logic [3:0]  reg_e;
  logic [2:0]  reg_e3;
  logic [2:0]  reg_fs, reg_fs3;
  logic [63:0] reg_q;
  logic [47:0] reg_q3;
  logic        busy, busy3;

  logic [15:0] bank [4];
  logic [15:0] bank3 [3];

  int n_pass = 0;
  int n_total = 0;

  regbank_op_arbiter #(.NUM_REQ(2), .NUM_REGS(4), .SEL_W(2)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid), .i_req_fun_sel(req_fs),
    .i_req_sel(req_sel), .i_req_data(req_data), .o_ack(ack), .o_rdata(rdata),
    .o_reg_e(reg_e), .o_reg_fun_sel(reg_fs), .o_reg_i(reg_i), .i_reg_q(reg_q), .o_busy(busy)
  );

  regbank_op_arbiter #(.NUM_REQ(2), .NUM_REGS(3), .SEL_W(2)) u_dut3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid3), .i_req_fun_sel(req_fs3),
    .i_req_sel(req_sel3), .i_req_data(req_data3), .o_ack(ack3), .o_rdata(rdata3),
    .o_reg_e(reg_e3), .o_reg_fun_sel(reg_fs3), .o_reg_i(reg_i3), .i_reg_q(reg_q3), .o_busy(busy3)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] bank_op(input logic [2:0] fs, input logic [15:0] q,
                                          input logic [15:0] d);
    case (fs)
      FS_DEC:    return q - 16'd1;
      FS_INC:    return q + 16'd1;
      FS_LOAD:   return d;
      FS_CLR:    return 16'h0000;
      FS_CLR_WL: return {8'h00, d[7:0]};
      FS_WL:     return {q[15:8], d[7:0]};
      FS_WH:     return {d[7:0], q[7:0]};
      default:   return {{8{d[7]}}, d[7:0]};
    endcase
  endfunction

  always_ff @(posedge clk or negedge bank_rst_n) begin
    if (!bank_rst_n) begin
      for (int k = 0; k < 4; k++) bank[k] <= 16'h0000;
      for (int k = 0; k < 3; k++) bank3[k] <= 16'h0000;
    end else begin
      for (int k = 0; k < 4; k++) if (reg_e[k]) bank[k] <= bank_op(reg_fs, bank[k], reg_i);
      for (int k = 0; k < 3; k++) if (reg_e3[k]) bank3[k] <= bank_op(reg_fs3, bank3[k], reg_i3);
    end
  end

  assign reg_q  = {bank[3], bank[2], bank[1], bank[0]};
  assign reg_q3 = {bank3[2], bank3[1], bank3[0]};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic set_req(input int r, input logic [2:0] fs, input logic [1:0] sel,
                         input logic [15:0] d);
    req_valid[r]       = 1'b1;
    req_fs[3*r +: 3]   = fs;
    req_sel[2*r +: 2]  = sel;
    req_data[16*r +: 16] = d;
  endtask

  typedef struct {
    int          req;
    logic [2:0]  fs;
    logic [1:0]  sel;
    logic [15:0] data;
    logic [15:0] exp_rdata;
    logic [3:0]  exp_rege;
  } vec_t;

  vec_t vecs[13];

  task automatic do_op(input vec_t v, input int idx);
    @(negedge clk);
    set_req(v.req, v.fs, v.sel, v.data);
    @(negedge clk);
    check($sformatf("v%0d issue reg_e", idx), 32'(reg_e), 32'(v.exp_rege));
    check($sformatf("v%0d issue reg_fs", idx), 32'(reg_fs), 32'(v.fs));
    check($sformatf("v%0d issue busy", idx), 32'(busy), 32'd1);
    check($sformatf("v%0d issue ack", idx), 32'(ack), 32'd0);
    @(negedge clk);
    check($sformatf("v%0d done ack", idx), 32'(ack), 32'(2'b01 << v.req));
    check($sformatf("v%0d done rdata", idx), 32'(rdata), 32'(v.exp_rdata));
    check($sformatf("v%0d done reg_e", idx), 32'(reg_e), 32'd0);
    req_valid = 2'b00;
    @(negedge clk);
    check($sformatf("v%0d idle busy", idx), 32'(busy), 32'd0);
    check($sformatf("v%0d idle ack", idx), 32'(ack), 32'd0);
  endtask

  task automatic do_op3(input logic [1:0] sel, input logic [15:0] d,
                        input logic [15:0] exp_rdata, input logic [2:0] exp_rege, input string tag);
    @(negedge clk);
    req_valid3 = 2'b01;
    req_fs3    = {3'b000, FS_LOAD};
    req_sel3   = {2'b00, sel};
    req_data3  = {16'h0000, d};
    @(negedge clk);
    check({tag, " reg_e"}, 32'(reg_e3), 32'(exp_rege));
    @(negedge clk);
    check({tag, " ack"}, 32'(ack3), 32'd1);
    check({tag, " rdata"}, 32'(rdata3), 32'(exp_rdata));
    req_valid3 = 2'b00;
    @(negedge clk);
    check({tag, " busy"}, 32'(busy3), 32'd0);
  endtask

  initial begin
    logic [1:0] exp_ack;
    req_valid = 2'b00; req_fs = 6'h00; req_sel = 4'h0; req_data = 32'h0;
    req_valid3 = 2'b00; req_fs3 = 6'h00; req_sel3 = 4'h0; req_data3 = 32'h0;

    vecs[0]  = '{0, FS_LOAD,   2'd1, 16'h1234, 16'h1234, 4'b0010};
    vecs[1]  = '{1, FS_LOAD,   2'd2, 16'hFFFF, 16'hFFFF, 4'b0100};
    vecs[2]  = '{1, FS_INC,    2'd2, 16'h0000, 16'h0000, 4'b0100};
    vecs[3]  = '{0, FS_DEC,    2'd2, 16'h0000, 16'hFFFF, 4'b0100};
    vecs[4]  = '{0, FS_LOAD,   2'd0, 16'hAB00, 16'hAB00, 4'b0001};
    vecs[5]  = '{1, FS_WH,     2'd0, 16'h0012, 16'h1200, 4'b0001};
    vecs[6]  = '{0, FS_SEXT,   2'd0, 16'h0080, 16'hFF80, 4'b0001};
    vecs[7]  = '{1, FS_CLR,    2'd1, 16'hFFFF, 16'h0000, 4'b0010};
    vecs[8]  = '{0, FS_WL,     2'd3, 16'h99CD, 16'h00CD, 4'b1000};
    vecs[9]  = '{1, FS_LOAD,   2'd3, 16'h5A5A, 16'h5A5A, 4'b1000};
    vecs[10] = '{1, FS_CLR_WL, 2'd3, 16'h1234, 16'h0034, 4'b1000};
    vecs[11] = '{0, FS_INC,    2'd1, 16'h0000, 16'h0001, 4'b0010};
    vecs[12] = '{1, FS_SEXT,   2'd3, 16'h807F, 16'h007F, 4'b1000};

    #1;
    check("reset ack", 32'(ack), 32'd0);
    check("reset rdata", 32'(rdata), 32'd0);
    check("reset reg_e", 32'(reg_e), 32'd0);
    check("reset reg_fs", 32'(reg_fs), 32'd0);
    check("reset reg_i", 32'(reg_i), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset busy3", 32'(busy3), 32'd0);
    @(negedge clk);
    rst_n = 1'b1; bank_rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 13; i++) do_op(vecs[i], i);

    // Reset asserted during ISSUE: op is dropped, outputs clear at once.
    @(negedge clk);
    set_req(0, FS_LOAD, 2'd1, 16'hBEEF);
    @(negedge clk);
    check("rstmid pre reg_e", 32'(reg_e), 32'h2);
    #1 rst_n = 1'b0;
    #1;
    check("rstmid reg_e", 32'(reg_e), 32'd0);
    check("rstmid ack", 32'(ack), 32'd0);
    check("rstmid busy", 32'(busy), 32'd0);
    check("rstmid reg_i", 32'(reg_i), 32'd0);
    check("rstmid reg_fs", 32'(reg_fs), 32'd0);
    @(negedge clk);
    check("rstmid held ack", 32'(ack), 32'd0);
    check("rstmid bank R1", 32'(bank[1]), 32'h0001);
    rst_n = 1'b1;
    @(negedge clk);
    check("rstmid reissue reg_e", 32'(reg_e), 32'h2);
    check("rstmid reissue ack", 32'(ack), 32'd0);
    @(negedge clk);
    check("rstmid done ack", 32'(ack), 32'd1);
    check("rstmid done rdata", 32'(rdata), 32'hBEEF);
    req_valid = 2'b00;
    @(negedge clk);
    check("rstmid idle busy", 32'(busy), 32'd0);

    // Fresh reset so the arbitration pointer starts at 0.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Contention: both requesters held continuously.
    set_req(0, FS_INC, 2'd0, 16'h0000);
    set_req(1, FS_INC, 2'd1, 16'h0000);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      exp_ack = 2'b00;
      if (c % 3 == 2) begin
`ifdef ARB_FIXED_PRIORITY_EN
        exp_ack = 2'b01;
`else
        exp_ack = ((c / 3) % 2 == 0) ? 2'b01 : 2'b10;
`endif
      end
      check($sformatf("contend c%0d ack", c), 32'(ack), 32'(exp_ack));
    end
    req_valid = 2'b00;
    @(negedge clk);

    // Three-register bank: select 3 is out of range.
    do_op3(2'd2, 16'h2222, 16'h2222, 3'b100, "bank3 sel2");
    do_op3(2'd3, 16'h1111, 16'h0000, 3'b000, "bank3 badsel");
    check("bank3 untouched R2", 32'(bank3[2]), 32'h2222);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
